// File: rtl/pc_fetch_unit.sv
// Program counter and single-in-flight fetch sequencer. Fetches one word, issues it to
// the decoder, then resolves BS/PS/Z on inst_ack to choose the next PC.
module pc_fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                INST_W    = 17,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                FETCH_TMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] Instruction_out,
    output logic              inst_valid,
    input  logic              inst_ack,
    input  logic [1:0]        BS,
    input  logic              PS,
    input  logic              Z,
    input  logic [ADDR_W-1:0] const_in,
    input  logic [ADDR_W-1:0] reg_a,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       retired_count,
    output logic              fetch_err
);
    localparam int TMO_W = (FETCH_TMO < 2) ? 1 : $clog2(FETCH_TMO + 1);

    typedef enum logic {FETCH, ISSUE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic [15:0]        ret_q, ret_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [ADDR_W-1:0]  pc_inc, pc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Branch resolution; const_in is already sign-extended so the add wraps naturally.
    always_comb begin
        pc_inc  = pc_q + 1'b1;
        pc_next = pc_inc;
        case (BS)
            2'b00: pc_next = pc_inc;
            2'b01: pc_next = (Z ^ PS) ? pc_inc + const_in : pc_inc;
            2'b10: pc_next = reg_a;
            2'b11: pc_next = const_in;
            default: pc_next = pc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ret_d   = ret_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    inst_d  = imem_rdata;
                    tmo_d   = '0;
                    state_d = ISSUE;
                end else if (tmo_q == TMO_W'(FETCH_TMO - 1)) begin
                    err_d = 1'b1;
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ISSUE: begin
                if (inst_ack) begin
                    pc_d    = pc_next;
                    ret_d   = ret_q + 16'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req        = (state_q == FETCH) && !rst;
    assign imem_addr       = pc_q;
    assign inst_valid      = (state_q == ISSUE);
    assign Instruction_out = inst_valid ? inst_q : '0;
    assign pc_out          = pc_q;
    assign retired_count   = ret_q;
    assign fetch_err       = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed branch cases plus randomized
// fetch/ack traffic compared against an arithmetic PC/retire model.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [16:0] imem_rdata;
    logic [16:0] Instruction_out;
    logic        inst_valid;
    logic        inst_ack;
    logic [1:0]  BS;
    logic        PS;
    logic        Z;
    logic [7:0]  const_in;
    logic [7:0]  reg_a;
    logic [7:0]  pc_out;
    logic [15:0] retired_count;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;
    int m_pc;
    int m_ret;

    pc_fetch_unit #(.ADDR_W(8), .INST_W(17), .RESET_PC(8'h00), .FETCH_TMO(15)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .Instruction_out(Instruction_out), .inst_valid(inst_valid), .inst_ack(inst_ack),
        .BS(BS), .PS(PS), .Z(Z), .const_in(const_in), .reg_a(reg_a),
        .pc_out(pc_out), .retired_count(retired_count), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic int model_next(int pc, int bs, int ps, int z, int c, int ra);
        int sc;
        sc = (c >= 128) ? c - 256 : c;
        case (bs)
            0: return (pc + 1) % 256;
            1: return (z != ps) ? (pc + 1 + sc + 256) % 256 : (pc + 1) % 256;
            2: return ra;
            default: return c;
        endcase
    endfunction

    // Stimulus only: present a word after lat idle cycles, optionally with stray acks.
    task automatic fetch_word(input logic [16:0] w, input int lat, input bit stray_ack);
        for (int i = 0; i < lat; i++) begin
            imem_valid = 1'b0;
            inst_ack   = stray_ack;
            BS         = 2'($urandom_range(0, 3));
            const_in   = 8'($urandom);
            reg_a      = 8'($urandom);
            @(negedge clk);
        end
        inst_ack   = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_valid = 1'b0;
    endtask

    task automatic ack(input int bs, input int ps, input int z, input int c, input int ra);
        BS = 2'(bs); PS = 1'(ps); Z = 1'(z); const_in = 8'(c); reg_a = 8'(ra);
        inst_ack = 1'b1;
        @(negedge clk);
        inst_ack = 1'b0;
        m_pc  = model_next(m_pc, bs, ps, z, c, ra);
        m_ret = (m_ret + 1) % 65536;
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; inst_ack = 1'b0;
        BS = 2'b00; PS = 1'b0; Z = 1'b0; const_in = '0; reg_a = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || Instruction_out !== 17'd0 ||
            pc_out !== 8'h00 || retired_count !== 16'd0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%b vld=%b inst=%h pc=%h ret=%0d err=%b (want 0,0,0,00,0,0)",
                     imem_req, inst_valid, Instruction_out, pc_out, retired_count, fetch_err);
        end
        rst = 1'b0;
        m_pc = 0; m_ret = 0;
    endtask

    task automatic test_first_fetch;
        imem_valid = 1'b1; imem_rdata = 17'h1_A5C3;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL fetch_req: req=%b addr=%h want 1,00", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || Instruction_out !== 17'h1_A5C3 || pc_out !== 8'h00 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_issue: vld=%b inst=%h pc=%h req=%b want 1,1a5c3,00,0",
                     inst_valid, Instruction_out, pc_out, imem_req);
        end
        ack(0, 0, 0, 0, 0);
        checks++;
        if (pc_out !== 8'h01 || retired_count !== 16'd1 || inst_valid !== 1'b0 || Instruction_out !== 17'd0) begin
            errors++;
            $display("FAIL first_ack: pc=%h ret=%0d vld=%b inst=%h want 01,1,0,0",
                     pc_out, retired_count, inst_valid, Instruction_out);
        end
    endtask

    task automatic test_wrap;
        fetch_word(17'h00001, 0, 1'b0);
        ack(3, 0, 0, 8'hFF, 0);
        checks++;
        if (pc_out !== 8'hFF) begin
            errors++;
            $display("FAIL jump_ff: pc=%h want ff", pc_out);
        end
        fetch_word(17'h00002, 0, 1'b0);
        ack(0, 0, 0, 0, 0);
        checks++;
        if (pc_out !== 8'h00 || retired_count !== 16'(m_ret)) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h ret=%0d want 00,%0d", pc_out, retired_count, m_ret);
        end
    endtask

    task automatic test_branch;
        fetch_word(17'h0, 0, 1'b0); ack(3, 0, 0, 8'h10, 0);
        fetch_word(17'h0, 0, 1'b0); ack(1, 0, 1, 8'hFE, 0);
        checks++;
        if (pc_out !== 8'h0F) begin
            errors++; $display("FAIL br_taken_back: pc=%h want 0f", pc_out);
        end
        fetch_word(17'h0, 0, 1'b0); ack(3, 0, 0, 8'h10, 0);
        fetch_word(17'h0, 0, 1'b0); ack(1, 0, 0, 8'hFE, 0);
        checks++;
        if (pc_out !== 8'h11) begin
            errors++; $display("FAIL br_not_taken: pc=%h want 11", pc_out);
        end
        fetch_word(17'h0, 0, 1'b0); ack(3, 0, 0, 8'h20, 0);
        fetch_word(17'h0, 0, 1'b0); ack(1, 1, 0, 8'h04, 0);
        checks++;
        if (pc_out !== 8'h25) begin
            errors++; $display("FAIL br_ps1: pc=%h want 25", pc_out);
        end
        fetch_word(17'h0, 0, 1'b0); ack(1, 1, 1, 8'h04, 0);
        checks++;
        if (pc_out !== 8'h26) begin
            errors++; $display("FAIL br_ps1_nt: pc=%h want 26", pc_out);
        end
    endtask

    task automatic test_jumps;
        fetch_word(17'h0, 0, 1'b0); ack(2, 0, 0, 8'h55, 8'h3C);
        checks++;
        if (pc_out !== 8'h3C) begin
            errors++; $display("FAIL jump_reg: pc=%h want 3c", pc_out);
        end
        fetch_word(17'h0, 0, 1'b0); ack(3, 0, 0, 8'h80, 8'h11);
        checks++;
        if (pc_out !== 8'h80 || retired_count !== 16'(m_ret)) begin
            errors++; $display("FAIL jump_abs: pc=%h ret=%0d want 80,%0d", pc_out, retired_count, m_ret);
        end
    endtask

    task automatic test_random;
        logic [16:0] w;
        int bs, ps, z, c, ra;
        for (int n = 0; n < 60; n++) begin
            w = 17'($urandom);
            fetch_word(w, $urandom_range(0, 5), 1'($urandom));
            checks++;
            if (inst_valid !== 1'b1 || Instruction_out !== w || pc_out !== 8'(m_pc)) begin
                errors++;
                $display("FAIL rnd_issue[%0d]: vld=%b inst=%h pc=%h want 1,%h,%h",
                         n, inst_valid, Instruction_out, pc_out, w, 8'(m_pc));
            end
            if ($urandom_range(0, 1) == 1) begin
                imem_valid = 1'b1; imem_rdata = ~w;
                @(negedge clk);
                imem_valid = 1'b0;
                checks++;
                if (Instruction_out !== w || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_hold[%0d]: inst=%h req=%b want %h,0", n, Instruction_out, imem_req, w);
                end
            end
            bs = $urandom_range(0, 3); ps = $urandom_range(0, 1); z = $urandom_range(0, 1);
            c = $urandom_range(0, 255); ra = $urandom_range(0, 255);
            ack(bs, ps, z, c, ra);
            checks++;
            if (pc_out !== 8'(m_pc) || retired_count !== 16'(m_ret) || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL rnd_ack[%0d]: pc=%h ret=%0d vld=%b want %h,%0d,0",
                         n, pc_out, retired_count, inst_valid, 8'(m_pc), m_ret);
            end
        end
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++; $display("FAIL no_spurious_err: err=%b want 0", fetch_err);
        end
    endtask

    task automatic test_timeout;
        imem_valid = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL tmo_early: err=%b req=%b want 0,1", fetch_err, imem_req);
        end
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 8'(m_pc)) begin
            errors++;
            $display("FAIL tmo_hit: err=%b req=%b addr=%h want 1,1,%h", fetch_err, imem_req, imem_addr, 8'(m_pc));
        end
        fetch_word(17'h0_BEEF, 3, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || Instruction_out !== 17'h0_BEEF || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_recover: vld=%b inst=%h err=%b want 1,0beef,1", inst_valid, Instruction_out, fetch_err);
        end
        ack(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_issue;
        fetch_word(17'h1_2345, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || Instruction_out !== 17'd0 || pc_out !== 8'h00 ||
            retired_count !== 16'd0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue: vld=%b inst=%h pc=%h ret=%0d err=%b want 0,0,00,0,0",
                     inst_valid, Instruction_out, pc_out, retired_count, fetch_err);
        end
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL rst_refetch: req=%b addr=%h want 1,00", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_wrap;
        test_branch;
        test_jumps;
        test_random;
        test_timeout;
        test_reset_issue;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
